// File: rtl/gpu_regwb.sv
// gpu_regwb: write-back arbiter merging ALU results and load returns into register-file port B, with pending-load scoreboard
module gpu_regwb #(
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic        sys_clk,
  input  logic        resetl,
  input  logic        alu_we,
  input  logic [5:0]  alu_reg,
  input  logic [31:0] alu_data,
  output logic        alu_stall,
  input  logic        ld_issue,
  input  logic [5:0]  ld_reg,
  output logic        ld_issue_ok,
  input  logic        ld_valid,
  input  logic [5:0]  ld_wreg,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  input  logic [5:0]  qa_reg,
  input  logic [5:0]  qb_reg,
  output logic        qa_busy,
  output logic        qb_busy,
  output logic        rf_nwe,
  output logic        rf_clk,
  output logic [5:0]  rf_addr,
  output logic [31:0] rf_data,
  output logic [2:0]  fifo_cnt,
  output logic        err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [37:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic [63:0] pending, pending_nxt;
  logic [SW-1:0] starve, starve_nxt;
  logic full, empty, alu_win, pop, push;
  logic [37:0] head;
  assign full = cnt == (AW+1)'(FIFO_DEPTH);
  assign empty = cnt == '0;
  assign alu_win = alu_we && !alu_stall;
  assign pop = !alu_win && !empty;
  assign push = ld_valid && !full;
  assign head = mem[rp];
  assign ld_ready = !full;
  assign ld_issue_ok = !pending[ld_reg];
  assign qa_busy = pending[qa_reg];
  assign qb_busy = pending[qb_reg];
  assign fifo_cnt = 3'(cnt);
  always_comb begin
    pending_nxt = pending;
    if (pop) pending_nxt[head[37:32]] = 1'b0;
    if (ld_issue && ld_issue_ok) pending_nxt[ld_reg] = 1'b1;
    starve_nxt = (pop || empty) ? '0 : alu_win ? starve + 1'b1 : starve;
  end
  always_ff @(posedge sys_clk)
    if (push) mem[wp] <= {ld_wreg, ld_data};
  always_ff @(posedge sys_clk or negedge resetl)
    if (!resetl) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      pending <= '0;
      starve <= '0;
      alu_stall <= 1'b0;
      err <= 1'b0;
      rf_nwe <= 1'b1;
      rf_clk <= 1'b0;
      rf_addr <= '0;
      rf_data <= '0;
    end else begin
      pending <= pending_nxt;
      starve <= starve_nxt;
      // the forced drain happens in the stall cycle, which also clears the counter
      alu_stall <= starve_nxt == SW'(STARVE_MAX);
      err <= err | (alu_we && (alu_stall || pending[alu_reg])) | (ld_valid && full);
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      rf_nwe <= !(alu_win || pop);
      rf_clk <= alu_win || pop;
      if (alu_win) begin
        rf_addr <= alu_reg;
        rf_data <= alu_data;
      end else if (pop) begin
        rf_addr <= head[37:32];
        rf_data <= head[31:0];
      end
    end
endmodule

// File: tb/tb_gpu_regwb.sv
// tb_gpu_regwb: directed stimulus; expected rf writes queued and checked by a negedge monitor
module tb_gpu_regwb;
  logic sys_clk, resetl, alu_we, alu_stall, ld_issue, ld_issue_ok, ld_valid, ld_ready;
  logic qa_busy, qb_busy, rf_nwe, rf_clk, err;
  logic [5:0] alu_reg, ld_reg, ld_wreg, qa_reg, qb_reg, rf_addr;
  logic [31:0] alu_data, ld_data, rf_data;
  logic [2:0] fifo_cnt;
  logic [37:0] exp_q [$];
  logic [37:0] mon_e;
  int tests = 0, fails = 0;

  gpu_regwb dut (.sys_clk(sys_clk), .resetl(resetl), .alu_we(alu_we), .alu_reg(alu_reg),
    .alu_data(alu_data), .alu_stall(alu_stall), .ld_issue(ld_issue), .ld_reg(ld_reg),
    .ld_issue_ok(ld_issue_ok), .ld_valid(ld_valid), .ld_wreg(ld_wreg), .ld_data(ld_data),
    .ld_ready(ld_ready), .qa_reg(qa_reg), .qb_reg(qb_reg), .qa_busy(qa_busy), .qb_busy(qb_busy),
    .rf_nwe(rf_nwe), .rf_clk(rf_clk), .rf_addr(rf_addr), .rf_data(rf_data),
    .fifo_cnt(fifo_cnt), .err(err));

  initial sys_clk = 0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle_in;
    alu_we = 0;
    ld_issue = 0;
    ld_valid = 0;
  endtask

  task automatic alu(input logic [5:0] r, input logic [31:0] d);
    alu_we = 1;
    alu_reg = r;
    alu_data = d;
    exp_q.push_back({r, d});
  endtask

  task automatic ld(input logic [5:0] r, input logic [31:0] d);
    ld_valid = 1;
    ld_wreg = r;
    ld_data = d;
  endtask

  always @(negedge sys_clk)
    if (resetl === 1'b1 && rf_nwe === 1'b0) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL rf_write: unexpected write addr %0d data %h", rf_addr, rf_data);
      end else begin
        mon_e = exp_q.pop_front();
        if ({rf_addr, rf_data} !== mon_e || rf_clk !== 1'b1) begin
          fails++;
          $display("FAIL rf_write: got addr %0d data %h clk %b expected addr %0d data %h clk 1",
                   rf_addr, rf_data, rf_clk, mon_e[37:32], mon_e[31:0]);
        end
      end
    end

  initial begin
    idle_in();
    alu_reg = 0; alu_data = 0; ld_reg = 0; ld_wreg = 0; ld_data = 0; qa_reg = 0; qb_reg = 0;
    resetl = 0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_nwe", rf_nwe, 1);
    chk("rst_clk", rf_clk, 0);
    chk("rst_addr", rf_addr, 0);
    chk("rst_data", rf_data, 0);
    chk("rst_stall", alu_stall, 0);
    chk("rst_err", err, 0);
    chk("rst_cnt", fifo_cnt, 0);
    chk("rst_ready", ld_ready, 1);
    @(negedge sys_clk) resetl = 1;
    tick();
    // single ALU write, one-cycle latency, then idle holds address
    alu(5, 32'h12345678);
    tick();
    idle_in();
    chk("alu_nwe", rf_nwe, 0);
    chk("alu_clk", rf_clk, 1);
    chk("alu_addr", rf_addr, 5);
    chk("alu_data", rf_data, 32'h12345678);
    tick();
    chk("idle_nwe", rf_nwe, 1);
    chk("idle_clk", rf_clk, 0);
    chk("idle_hold", rf_addr, 5);
    // load issue, hazard query, return and clear
    ld_issue = 1; ld_reg = 10; qa_reg = 10; qb_reg = 11;
    #1;
    chk("issue_ok_free", ld_issue_ok, 1);
    chk("qa_free", qa_busy, 0);
    tick();
    ld_issue = 0;
    #1;
    chk("qa_busy_set", qa_busy, 1);
    chk("qb_other", qb_busy, 0);
    chk("issue_ok_blk", ld_issue_ok, 0);
    ld_issue = 1;
    tick();
    ld_issue = 0;
    chk("retry_busy", qa_busy, 1);
    chk("retry_err", err, 0);
    ld(10, 32'hCAFEF00D);
    exp_q.push_back({6'd10, 32'hCAFEF00D});
    tick();
    idle_in();
    chk("ld_cnt1", fifo_cnt, 1);
    chk("ld_nobypass", rf_nwe, 1);
    chk("ld_busy_q", qa_busy, 1);
    tick();
    chk("ld_nwe", rf_nwe, 0);
    chk("ld_addr", rf_addr, 10);
    chk("ld_clear", qa_busy, 0);
    chk("ld_cnt0", fifo_cnt, 0);
    chk("ld_err", err, 0);
    // starvation: 8 ALU wins with FIFO non-empty force a one-cycle stall
    for (int i = 0; i < 9; i++) begin
      alu(6'(i + 1), 32'h10000000 + i);
      if (i < 2) ld(6'(20 + i), 32'hD0000000 + i);
      tick();
      idle_in();
      if (i == 7) chk("starve7_nostall", alu_stall, 0);
    end
    chk("stall_set", alu_stall, 1);
    chk("stall_cnt", fifo_cnt, 2);
    chk("stall_err0", err, 0);
    alu_we = 1; alu_reg = 40; alu_data = 32'hDEADDEAD;
    exp_q.push_back({6'd20, 32'hD0000000});
    tick();
    idle_in();
    chk("stall_clr", alu_stall, 0);
    chk("stall_drop_err", err, 1);
    chk("stall_cnt1", fifo_cnt, 1);
    exp_q.push_back({6'd21, 32'hD0000001});
    tick();
    chk("stall_cnt0", fifo_cnt, 0);
    tick();
    resetl = 0;
    #1;
    chk("err_rst", err, 0);
    @(negedge sys_clk) resetl = 1;
    tick();
    // fill FIFO under ALU pressure, then overflow
    for (int i = 0; i < 4; i++) begin
      alu(6'(11 + i), 32'h20000000 + i);
      ld(6'(20 + i), 32'hE0000000 + i);
      tick();
      idle_in();
    end
    chk("full_cnt", fifo_cnt, 4);
    chk("full_ready", ld_ready, 0);
    chk("full_err0", err, 0);
    alu(15, 32'h20000004);
    ld(30, 32'hBAD0BAD0);
    tick();
    idle_in();
    chk("ovf_err", err, 1);
    chk("ovf_cnt", fifo_cnt, 4);
    for (int i = 0; i < 4; i++) exp_q.push_back({6'(20 + i), 32'hE0000000 + i});
    repeat (4) tick();
    chk("drain_cnt", fifo_cnt, 0);
    // simultaneous push/pop at depth 2, pointers wrap
    for (int i = 0; i < 6; i++) begin
      if (i < 2) alu(6'(16 + i), 32'h30000000 + i);
      ld(6'(32 + i), 32'hF0000000 + i);
      if (i == 2) for (int k = 0; k < 6; k++) exp_q.push_back({6'(32 + k), 32'hF0000000 + k});
      tick();
      idle_in();
      if (i >= 2) chk("pushpop_cnt", fifo_cnt, 2);
    end
    repeat (2) tick();
    chk("wrap_cnt0", fifo_cnt, 0);
    // reset mid-operation with queued loads and pending bits
    ld_issue = 1; ld_reg = 50;
    tick();
    ld_reg = 51;
    tick();
    ld_issue = 0; qa_reg = 50; qb_reg = 51;
    #1;
    chk("pend50", qa_busy, 1);
    chk("pend51", qb_busy, 1);
    for (int i = 0; i < 3; i++) begin
      alu(6'(1 + i), 32'h40000000 + i);
      ld(6'(50 + i), 32'h60000000 + i);
      tick();
      idle_in();
    end
    chk("mid_cnt", fifo_cnt, 3);
    @(negedge sys_clk);
    #1;
    resetl = 0;
    #1;
    chk("mid_nwe", rf_nwe, 1);
    chk("mid_clk", rf_clk, 0);
    chk("mid_addr", rf_addr, 0);
    chk("mid_data", rf_data, 0);
    chk("mid_cnt0", fifo_cnt, 0);
    chk("mid_qa", qa_busy, 0);
    chk("mid_qb", qb_busy, 0);
    chk("mid_ready", ld_ready, 1);
    @(negedge sys_clk) resetl = 1;
    repeat (5) tick();
    chk("post_nwe", rf_nwe, 1);
    chk("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
